// File: rtl/sccb_cam_master.sv
// rtl/sccb_cam_master.sv - SCCB (I2C-style, 16-bit register address) camera control master
// Optional one-entry pending command register enabled by defining SCCB_CMD_QUEUE_EN.
module sccb_cam_master #(
    parameter int CLK_DIV = 250
) (
    input  logic        fclk,
    input  logic        rst_n,
    input  logic [31:0] cmd,
    input  logic        cmd_valid,
    output logic [17:0] resp,
    output logic        resp_valid,
    output logic        busy,
    output logic        cmd_dropped,
    output logic        scl,
    output logic        sda_oe,
    input  logic        sda_i
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_TXBYTE, S_STOP, S_RESTART, S_RXBYTE, S_RESP
    } state_t;

    state_t      r_state;
    logic [15:0] r_tick_cnt;
    logic [1:0]  r_q;
    logic [3:0]  r_bit;
    logic [1:0]  r_byte;
    logic        r_phase2;
    logic [31:0] r_cmd;
    logic [7:0]  r_shift;
    logic [7:0]  r_rx;
    logic        r_nack;
    logic [17:0] r_resp;
    logic        r_resp_valid;
    logic        r_busy;
    logic        r_scl;
    logic        r_sda_oe;

    logic        w_tick;
    logic        w_free;
    logic        w_accept;
    logic        w_drop;
    logic        w_chain;
    logic [31:0] w_start_cmd;
    logic [1:0]  w_last_byte;
    logic [7:0]  w_first_byte;
    logic [7:0]  w_next_byte;

    // Byte stream of one transfer; the phase-2 byte is the read address after RESTART.
    function automatic logic [7:0] tx_byte(input logic [31:0] c, input logic [1:0] idx,
                                           input logic p2);
        logic [7:0] b;
        if (p2) begin
            b = {c[30:24], 1'b1};
        end else begin
            case (idx)
                2'd0:    b = {c[30:24], 1'b0};
                2'd1:    b = c[23:16];
                2'd2:    b = c[15:8];
                default: b = c[7:0];
            endcase
        end
        return b;
    endfunction

`ifdef SCCB_CMD_QUEUE_EN
    logic        r_pend_valid;
    logic [31:0] r_pend_cmd;
    logic        w_store;
`endif

    always_comb begin
        w_tick       = (r_state != S_IDLE) && (r_tick_cnt == 16'(CLK_DIV - 1));
        w_free       = (r_state == S_IDLE) && !r_busy;
        w_accept     = cmd_valid && w_free;
        w_last_byte  = r_cmd[31] ? 2'd2 : 2'd3;
        w_first_byte = tx_byte(r_cmd, 2'd0, r_phase2);
        w_next_byte  = tx_byte(r_cmd, r_byte + 2'd1, 1'b0);
`ifdef SCCB_CMD_QUEUE_EN
        w_store      = cmd_valid && !w_free && !r_pend_valid;
        w_drop       = cmd_valid && !w_free && r_pend_valid;
        // A command arriving in the response cycle goes straight to START without parking.
        w_chain      = r_resp_valid && (r_pend_valid || w_store);
        w_start_cmd  = (r_resp_valid && r_pend_valid) ? r_pend_cmd : cmd;
`else
        w_drop       = cmd_valid && !w_free;
        w_chain      = 1'b0;
        w_start_cmd  = cmd;
`endif
    end

`ifdef SCCB_CMD_QUEUE_EN
    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            r_pend_valid <= 1'b0;
            r_pend_cmd   <= '0;
        end else if (w_chain) begin
            r_pend_valid <= 1'b0;
        end else if (w_store) begin
            r_pend_valid <= 1'b1;
            r_pend_cmd   <= cmd;
        end
    end
`endif

    // Outputs for the next quarter are loaded on the tick that ends the current one.
    always_ff @(posedge fclk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_tick_cnt   <= '0;
            r_q          <= '0;
            r_bit        <= '0;
            r_byte       <= '0;
            r_phase2     <= 1'b0;
            r_cmd        <= '0;
            r_shift      <= '0;
            r_rx         <= '0;
            r_nack       <= 1'b0;
            r_resp       <= '0;
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_scl        <= 1'b1;
            r_sda_oe     <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            if (r_state == S_IDLE || w_tick) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 16'd1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept || w_chain) begin
                        r_cmd    <= w_start_cmd;
                        r_state  <= S_START;
                        r_q      <= '0;
                        r_byte   <= '0;
                        r_phase2 <= 1'b0;
                        r_nack   <= 1'b0;
                        r_busy   <= 1'b1;
                    end else if (r_resp_valid) begin
                        r_busy <= 1'b0;
                    end
                end

                S_START, S_RESTART: begin
                    if (w_tick) begin
                        r_q <= r_q + 2'd1;
                        case (r_q)
                            2'd0: r_sda_oe <= 1'b1;
                            2'd1: r_scl    <= 1'b0;
                            2'd2: ;
                            default: begin
                                r_state  <= S_TXBYTE;
                                r_bit    <= '0;
                                r_shift  <= w_first_byte;
                                r_sda_oe <= ~w_first_byte[7];
                            end
                        endcase
                    end
                end

                S_TXBYTE: begin
                    if (w_tick) begin
                        r_q <= r_q + 2'd1;
                        case (r_q)
                            2'd0: r_scl <= 1'b1;
                            2'd1: ;
                            2'd2: begin
                                r_scl <= 1'b0;
                                if (r_bit == 4'd8 && sda_i) begin
                                    r_nack <= 1'b1;
                                end
                            end
                            default: begin
                                if (r_bit != 4'd8) begin
                                    r_bit    <= r_bit + 4'd1;
                                    r_shift  <= {r_shift[6:0], 1'b0};
                                    r_sda_oe <= (r_bit == 4'd7) ? 1'b0 : ~r_shift[6];
                                end else if (r_phase2) begin
                                    r_state  <= S_RXBYTE;
                                    r_bit    <= '0;
                                    r_sda_oe <= 1'b0;
                                end else if (r_byte != w_last_byte) begin
                                    r_byte   <= r_byte + 2'd1;
                                    r_bit    <= '0;
                                    r_shift  <= w_next_byte;
                                    r_sda_oe <= ~w_next_byte[7];
                                end else begin
                                    r_state  <= S_STOP;
                                    r_sda_oe <= 1'b1;
                                end
                            end
                        endcase
                    end
                end

                S_RXBYTE: begin
                    if (w_tick) begin
                        r_q <= r_q + 2'd1;
                        case (r_q)
                            2'd0: r_scl <= 1'b1;
                            2'd1: ;
                            2'd2: begin
                                r_scl <= 1'b0;
                                if (r_bit != 4'd8) begin
                                    r_rx <= {r_rx[6:0], sda_i};
                                end
                            end
                            default: begin
                                if (r_bit != 4'd8) begin
                                    r_bit <= r_bit + 4'd1;
                                end else begin
                                    r_state  <= S_STOP;
                                    r_sda_oe <= 1'b1;
                                end
                            end
                        endcase
                    end
                end

                S_STOP: begin
                    if (w_tick) begin
                        r_q <= r_q + 2'd1;
                        case (r_q)
                            2'd0: r_scl    <= 1'b1;
                            2'd1: r_sda_oe <= 1'b0;
                            2'd2: ;
                            default: begin
                                if (r_cmd[31] && !r_phase2) begin
                                    r_state  <= S_RESTART;
                                    r_phase2 <= 1'b1;
                                end else begin
                                    r_state <= S_RESP;
                                end
                            end
                        endcase
                    end
                end

                S_RESP: begin
                    r_resp       <= {r_nack, r_cmd[31], r_cmd[15:8],
                                     r_cmd[31] ? r_rx : r_cmd[7:0]};
                    r_resp_valid <= 1'b1;
                    r_state      <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign resp        = r_resp;
    assign resp_valid  = r_resp_valid;
    assign busy        = r_busy;
    assign cmd_dropped = w_drop && rst_n;
    assign scl         = r_scl;
    assign sda_oe      = r_sda_oe;

endmodule

// File: tb/tb_sccb_cam_master.sv
// tb/tb_sccb_cam_master.sv - scoreboard bench for sccb_cam_master with bus decoder and slave model
`timescale 1ns/1ps
module tb_sccb_cam_master;
    localparam int D2 = 2;
    localparam int D3 = 3;
    localparam int LW = 152 * D2 + 2;
    localparam int LR = 196 * D2 + 2;
`ifdef SCCB_CMD_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    logic        fclk = 1'b0;
    always #5 fclk = ~fclk;

    logic        rst_n = 1'b0;
    logic [31:0] cmd = '0;
    logic        cmd_valid = 1'b0;
    logic [17:0] resp;
    logic        resp_valid, busy, cmd_dropped, scl, sda_oe, sda_i;
    logic        slave_drv = 1'b1;
    assign sda_i = ~sda_oe & slave_drv;

    logic [31:0] cmd3 = '0;
    logic        cmd_valid3 = 1'b0;
    logic [17:0] resp3;
    logic        rv3, busy3, drop3, scl3, oe3;
    logic        sda3_i = 1'b0;

    sccb_cam_master #(.CLK_DIV(D2)) u_dut (
        .fclk(fclk), .rst_n(rst_n), .cmd(cmd), .cmd_valid(cmd_valid),
        .resp(resp), .resp_valid(resp_valid), .busy(busy), .cmd_dropped(cmd_dropped),
        .scl(scl), .sda_oe(sda_oe), .sda_i(sda_i)
    );

    sccb_cam_master #(.CLK_DIV(D3)) u_dut3 (
        .fclk(fclk), .rst_n(rst_n), .cmd(cmd3), .cmd_valid(cmd_valid3),
        .resp(resp3), .resp_valid(rv3), .busy(busy3), .cmd_dropped(drop3),
        .scl(scl3), .sda_oe(oe3), .sda_i(sda3_i)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge fclk) cyc <= cyc + 1;

    logic [17:0] exp_resp_q[$];
    int          exp_cyc_q[$];
    logic [7:0]  exp_byte_q[$];
    logic [7:0]  rx_q[$];
    int          m_done = -1;
    int          m_pend_until = -1;
    logic        ack_nack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: acceptance by cycle arithmetic, expected bytes/response from field rules.
    task automatic issue(input logic [31:0] c, input logic [7:0] rx);
        int  t;
        int  lat;
        bit  takes;
        bit  exp_drop;
        @(posedge fclk); #1;
        t = cyc;
        lat = c[31] ? LR : LW;
        takes = 1'b0;
        exp_drop = 1'b0;
        if (t > m_done) begin
            takes = 1'b1;
            m_done = t + lat;
        end else if (QEN && t > m_pend_until) begin
            takes = 1'b1;
            m_pend_until = m_done;
            m_done = m_done + lat;
        end else begin
            exp_drop = 1'b1;
        end
        if (takes) begin
            exp_resp_q.push_back({ack_nack, c[31], c[15:8], c[31] ? rx : c[7:0]});
            exp_cyc_q.push_back(m_done);
            exp_byte_q.push_back({c[30:24], 1'b0});
            exp_byte_q.push_back(c[23:16]);
            exp_byte_q.push_back(c[15:8]);
            if (c[31]) begin
                exp_byte_q.push_back({c[30:24], 1'b1});
                exp_byte_q.push_back(rx);
                rx_q.push_back(rx);
            end else begin
                exp_byte_q.push_back(c[7:0]);
            end
        end
        cmd = c;
        cmd_valid = 1'b1;
        @(negedge fclk);
        check("cmd_dropped", {31'd0, cmd_dropped}, {31'd0, exp_drop});
        @(posedge fclk); #1;
        cmd_valid = 1'b0;
        @(negedge fclk);
        if (takes) check("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        int lim;
        lim = m_done + 4;
        while (cyc < lim) @(posedge fclk);
        @(negedge fclk);
        check("resp_drained", exp_resp_q.size(), 0);
        check("bytes_drained", exp_byte_q.size(), 0);
    endtask

    function automatic logic [31:0] rand_cmd(input bit rd);
        logic [31:0] c;
        c = $urandom;
        c[31] = rd;
        return c;
    endfunction

    // Response monitor
    initial begin : resp_mon
        logic [17:0] e;
        int          ec;
        forever begin
            @(negedge fclk);
            if (resp_valid) begin
                if (exp_resp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp actual=%0h required=none", resp);
                end else begin
                    e = exp_resp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("resp_value", {14'd0, resp}, {14'd0, e});
                    check("resp_cycle", cyc, ec);
                end
            end
        end
    end

    // Bus decoder plus slave: ACKs address/register bytes, drives read data while SCL is low.
    initial begin : bus_mon
        logic       p_scl, p_sda, l_sda, rd;
        int         nbit, nbyte;
        logic [7:0] sh, rx_cur, e;
        p_scl = 1'b1; p_sda = 1'b1; rd = 1'b0;
        nbit = 0; nbyte = 0; sh = '0; rx_cur = 8'hFF;
        forever begin
            @(negedge fclk);
            l_sda = sda_i;
            if (!rst_n) begin
                nbit = 0; nbyte = 0; rd = 1'b0;
                slave_drv = 1'b1;
            end else if (p_scl && scl && (p_sda != l_sda)) begin
                nbit = 0; nbyte = 0; rd = 1'b0;
            end else if (!p_scl && scl) begin
                if (nbit < 8) sh = {sh[6:0], l_sda};
                nbit++;
                if (nbit == 9) begin
                    if (exp_byte_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_bus_byte actual=%0h required=none", sh);
                    end else begin
                        e = exp_byte_q.pop_front();
                        check("bus_byte", {24'd0, sh}, {24'd0, e});
                    end
                    if (nbyte == 0) rd = sh[0];
                    nbyte++;
                    nbit = 0;
                end
            end else if (p_scl && !scl) begin
                if (rd && nbyte == 1) begin
                    if (nbit == 0) rx_cur = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hFF;
                    slave_drv = (nbit < 8) ? rx_cur[7 - nbit] : 1'b1;
                end else begin
                    slave_drv = (nbit == 8) ? ack_nack : 1'b1;
                end
            end
            p_scl = scl;
            p_sda = sda_i;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] c;
        int run, nhi, nlo, badhi, badlo, rvw, rvc, t0;
        logic p, first_hi;
        logic [17:0] r3;

        repeat (3) @(posedge fclk);
        @(negedge fclk);
        check("rst_scl", {31'd0, scl}, 32'd1);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_resp", {14'd0, resp}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_cmd_dropped", {31'd0, cmd_dropped}, 32'd0);
        @(posedge fclk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge fclk);

        issue(32'h3C30_0880, 8'h00);
        wait_done();
        issue(32'hBC30_0A00, 8'h56);
        wait_done();

        ack_nack = 1'b1;
        issue(rand_cmd(1'b0), 8'h00);
        wait_done();
        ack_nack = 1'b0;

        issue(rand_cmd(1'b0), 8'h00);
        repeat (8) @(posedge fclk);
        issue(rand_cmd(1'b1), 8'($urandom));
        repeat (8) @(posedge fclk);
        issue(rand_cmd(1'b0), 8'h00);
        wait_done();

        issue(rand_cmd(1'b0), 8'h00);
        repeat (60) @(posedge fclk);
        #1;
        rst_n = 1'b0;
        exp_resp_q.delete();
        exp_cyc_q.delete();
        exp_byte_q.delete();
        rx_q.delete();
        m_done = -1;
        m_pend_until = -1;
        @(posedge fclk); #1;
        rst_n = 1'b1;
        @(negedge fclk);
        check("abort_scl", {31'd0, scl}, 32'd1);
        check("abort_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (4) @(posedge fclk);
        issue(rand_cmd(1'b0), 8'h00);
        wait_done();

        for (int i = 0; i < 6; i++) begin
            issue(rand_cmd(1'($urandom_range(0, 1))), 8'($urandom));
            wait_done();
            repeat ($urandom_range(0, 5)) @(posedge fclk);
        end

        c = rand_cmd(1'b0);
        @(posedge fclk); #1;
        t0 = cyc;
        cmd3 = c;
        cmd_valid3 = 1'b1;
        @(negedge fclk);
        check("d3_drop", {31'd0, drop3}, 32'd0);
        @(posedge fclk); #1;
        cmd_valid3 = 1'b0;
        run = 0; nhi = 0; nlo = 0; badhi = 0; badlo = 0; rvw = 0; rvc = -1;
        p = 1'b1; first_hi = 1'b1; r3 = '0;
        for (int k = 0; k < 520; k++) begin
            @(negedge fclk);
            if (k == 0) check("d3_busy", {31'd0, busy3}, 32'd1);
            if (scl3 == p) begin
                run++;
            end else begin
                if (p) begin
                    if (first_hi) first_hi = 1'b0;
                    else begin
                        nhi++;
                        if (run != 2 * D3) badhi++;
                    end
                end else begin
                    nlo++;
                    if ((nlo == 1 && run != 3 * D3) || (nlo > 1 && run != 2 * D3)) badlo++;
                end
                run = 1;
                p = scl3;
            end
            if (rv3) begin
                rvw++;
                if (rvc < 0) begin
                    rvc = cyc;
                    r3 = resp3;
                end
            end
        end
        check("d3_scl_high_count", nhi, 36);
        check("d3_scl_high_width_bad", badhi, 0);
        check("d3_scl_low_count", nlo, 37);
        check("d3_scl_low_width_bad", badlo, 0);
        check("d3_resp_valid_width", rvw, 1);
        check("d3_resp_cycle", rvc, t0 + 152 * D3 + 2);
        check("d3_resp_value", {14'd0, r3}, {14'd0, 2'b00, c[15:8], c[7:0]});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sccb_cam_master.md
Name: sccb_cam_master

Overview:
- Camera-side control engine: consumes a 32-bit camera command word plus a one-cycle command strobe from the MMIO register block.
- Executes one SCCB (I2C-compatible, 16-bit register address) write or read on the camera control bus.
- Returns an 18-bit response word with a one-cycle response strobe; those feed the MMIO camera response/count registers.
- One instance per camera (cam0, cam1).

Parameters:
- CLK_DIV, 250, fclk cycles per quarter-bit tick; SCL period = 4*CLK_DIV (100 kHz at 100 MHz fclk); legal range 2..65535.

Ports:
- fclk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- cmd  in  32  command word; [31]=read(1)/write(0), [30:24]=7-bit device addr, [23:8]=register addr, [7:0]=write data
- cmd_valid  in  1  single-cycle strobe; cmd sampled on this cycle
- resp  out  18  [17]=NACK seen, [16]=was read, [15:8]=reg addr[7:0], [7:0]=read data (read) or written data (write)
- resp_valid  out  1  single-cycle strobe, resp stable from this cycle until the next command completes
- busy  out  1  high from the cycle after an accepted cmd_valid through the resp_valid cycle
- cmd_dropped  out  1  single-cycle pulse when cmd_valid arrives and cannot be accepted
- scl  out  1  SCCB clock; 1 = released
- sda_oe  out  1  1 = pull SDA low, 0 = release
- sda_i  in  1  SDA pad input (synchronised externally)

Behaviour:
- Reset (rst_n low at a clock edge), including mid-transfer:
  - state IDLE; scl=1, sda_oe=0; resp=0, resp_valid=0, busy=0, cmd_dropped=0; tick counter cleared.
  - No response is issued for an aborted transfer.
- Tick: counter runs only when not IDLE; a tick fires every CLK_DIV cycles. All bus phases advance on ticks. Each bit = 4 ticks:
  - q0: SCL low, drive SDA
  - q1: SCL high
  - q2: SCL high, sample sda_i
  - q3: SCL low
- States: IDLE, START, TXBYTE, STOP, RESTART, RXBYTE, RESP.
  - IDLE: on cmd_valid, latch cmd, go to START.
  - START (4 ticks): SDA released + SCL high, then SDA low, then SCL low.
  - TXBYTE: 8 data bits MSB first, then a 9th bit with SDA released. sda_i sampled high at q2 of bit 9 sets the sticky NACK flag. The transfer continues regardless (SCCB don't-care ACK).
  - Write sequence: START, {dev,0}, reg[15:8], reg[7:0], data, STOP.
  - Read sequence: START, {dev,0}, reg[15:8], reg[7:0], STOP, RESTART (= START), {dev,1}, RXBYTE, STOP.
  - RXBYTE: SDA released; 8 bits sampled at q2, MSB first; 9th bit master NACK (SDA released).
  - STOP (4 ticks): SDA low + SCL low, SCL high, SDA released, hold.
  - After the final STOP go to RESP: resp_valid=1 for exactly one cycle with the assembled resp, then IDLE.
- Latency, cmd_valid cycle to resp_valid cycle:
  - write: 152 ticks * CLK_DIV + 2 cycles
  - read: 196 ticks * CLK_DIV + 2 cycles
- cmd_valid while busy: command not accepted; cmd_dropped pulses the same cycle (see optional feature).
- cmd_valid in the RESP cycle counts as busy.
- Bus lines change only on tick edges; no glitches between ticks.

Optional Feature:
- SCCB_CMD_QUEUE_EN defined:
  - One-entry pending register. First cmd_valid while busy is stored with no drop.
  - The stored command starts the cycle after resp_valid; busy stays high throughout.
  - A second cmd_valid while the pending entry is occupied pulses cmd_dropped.
- Not defined: every cmd_valid while busy pulses cmd_dropped.

Test Plan:
- CLK_DIV=2, write cmd 0x3C_3008_80 (dev 0x3C, reg 0x3008, data 0x80), sda_i=0 at ACK bits:
  - SDA bytes 0x78, 0x30, 0x08, 0x80
  - resp_valid at cycle 306 with resp=0x00880
- CLK_DIV=2, read cmd 0xBC_300A_00, slave drives 0x56:
  - bytes 0x78, 0x30, 0x0A, then restart and 0x79
  - resp=0x10A56 at cycle 394
- Write with sda_i held 1 → resp[17]=1, all four bytes still shifted, normal latency.
- Second cmd_valid 10 cycles after the first:
  - macro off → cmd_dropped pulse, single transfer.
  - macro on → two back-to-back transfers, two resp_valid pulses.
- rst_n low mid-TXBYTE → next cycle scl=1, sda_oe=0, busy=0, no resp_valid; a new command afterwards completes normally.
- CLK_DIV=3 → SCL high/low widths exactly 6 cycles; resp_valid exactly 1 cycle wide.
